fetch_prefetch: RTL and testbench

Parametrised instruction-fetch stage with a prefetch FIFO and a req/gnt/rvalid memory handshake. It keeps up to DEPTH instructions in flight or buffered so that the pipeline is fed one instruction per cycle despite variable memory latency. It sits between busio and decode. Redirect inputs (trap, mret, branch) come from writeback, csr and memory; stall and invalidate come from hazard.

---
 rtl/fetch_prefetch.sv | 133 +++++++++++++
 tb/tb_fetch_prefetch.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch.sv
// Instruction fetch stage: prefetch FIFO fed by a req/gnt/rvalid memory port,
// with credit-limited requests and drop counting of stale responses on redirect.
module fetch_prefetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h8000_0000,
  parameter int          DEPTH        = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        branch,
  input  logic [31:0] branch_vector,
  input  logic        trap,
  input  logic        mret,
  input  logic [31:0] trap_vector,
  input  logic [31:0] mret_vector,
  input  logic        stall,
  input  logic        invalidate,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] next_pc_out,
  output logic [31:0] instruction_out,
  output logic        valid_out
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   req_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] count;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [31:0]   fifo_pc  [DEPTH];
  logic [31:0]   fifo_ins [DEPTH];

  logic          redirect;
  logic [31:0]   target;
  logic [CW:0]   used;
  logic          grant;
  logic          rsp;
  logic          drop;
  logic          push;
  logic          pop;

  always_comb begin
    if (trap)      target = trap_vector;
    else if (mret) target = mret_vector;
    else           target = branch_vector;
    target[1:0] = 2'b00;
  end

  assign redirect = trap | mret | branch;
  assign used     = {1'b0, count} + {1'b0, inflight};
  assign mem_req  = reset_n && !redirect && (used < LIMIT);
  assign mem_addr = req_pc;
  assign grant    = mem_req && mem_gnt;
  assign rsp      = mem_rvalid && (inflight != '0);
  assign drop     = rsp && (drop_cnt != '0);
  assign push     = rsp && !drop && !redirect;
  assign pop      = !redirect && !stall && !invalidate && (count != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_pc   <= RESET_VECTOR;
      resp_pc  <= RESET_VECTOR;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      inflight <= inflight + CW'(grant) - CW'(rsp);
      if (redirect) begin
        req_pc   <= target;
        resp_pc  <= target;
        drop_cnt <= inflight - CW'(rsp);
      end else begin
        if (grant) req_pc <= req_pc + 32'd4;
        if (drop)  drop_cnt <= drop_cnt - CW'(1);
        if (push)  resp_pc <= resp_pc + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (redirect) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wptr]  <= resp_pc;
      fifo_ins[wptr] <= mem_rdata;
    end
  end

  // Stall holds the slot; invalidate only kills valid and keeps the head queued.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_out          <= RESET_VECTOR;
      next_pc_out     <= RESET_VECTOR + 32'd4;
      instruction_out <= NOP;
      valid_out       <= 1'b0;
    end else if (redirect) begin
      valid_out <= 1'b0;
    end else if (stall) begin
      if (invalidate) valid_out <= 1'b0;
    end else begin
      valid_out <= (count != '0) && !invalidate;
      if (pop) begin
        pc_out          <= fifo_pc[rptr];
        next_pc_out     <= fifo_pc[rptr] + 32'd4;
        instruction_out <= fifo_ins[rptr];
      end
    end
  end

endmodule

// File: tb/tb_fetch_prefetch.sv
// Bench for fetch_prefetch: in-order memory responder, stream model of the
// expected fetch sequence, and directed scenarios with literal expectations.
module tb_fetch_prefetch;

  localparam logic [31:0] RV = 32'h8000_0000;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        branch, trap, mret, stall, invalidate;
  logic [31:0] branch_vector, trap_vector, mret_vector;
  logic        mem_req, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_rdata;
  logic [31:0] pc_out, next_pc_out, instruction_out;
  logic        valid_out;

  int checks = 0;
  int errors = 0;
  bit hold = 1'b0;
  logic [31:0] pend[$];

  always #5 clk = ~clk;

  fetch_prefetch #(.RESET_VECTOR(RV), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .branch(branch), .branch_vector(branch_vector),
    .trap(trap), .mret(mret),
    .trap_vector(trap_vector), .mret_vector(mret_vector),
    .stall(stall), .invalidate(invalidate),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .pc_out(pc_out), .next_pc_out(next_pc_out),
    .instruction_out(instruction_out), .valid_out(valid_out)
  );

  function automatic logic [31:0] ins_of(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string nm, input logic [31:0] exp_pc);
    int n = 0;
    @(negedge clk);
    while (!valid_out && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_valid"}, 32'(valid_out), 32'd1);
    chk({nm, "_pc"}, pc_out, exp_pc);
  endtask

  // In-order memory: zero-wait unless hold is set.
  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!reset_n) begin
        pend.delete();
        mem_rvalid = 1'b0;
      end else if (!hold && pend.size() > 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = ins_of(pend.pop_front());
      end else begin
        mem_rvalid = 1'b0;
      end
      @(negedge clk);
      if (reset_n && mem_req && mem_gnt) pend.push_back(mem_addr);
    end
  end

  // Stream model: outputs must walk the fetch sequence, restarting on redirect.
  initial begin : cmp
    logic [31:0] exp_pc, req_exp, tgt;
    bit kill_prev, redir;
    exp_pc = RV;
    req_exp = RV;
    kill_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        exp_pc = RV;
        req_exp = RV;
        kill_prev = 1'b0;
      end else begin
        redir = trap | mret | branch;
        tgt = trap ? trap_vector : (mret ? mret_vector : branch_vector);
        tgt[1:0] = 2'b00;
        if (kill_prev) chk("killed_slot", 32'(valid_out), 32'd0);
        if (valid_out) begin
          chk("pc_out", pc_out, exp_pc);
          chk("next_pc_out", next_pc_out, exp_pc + 32'd4);
          chk("instruction_out", instruction_out, ins_of(exp_pc));
        end
        if (mem_req) chk("mem_addr", mem_addr, req_exp);
        if (redir) chk("req_off_on_redirect", 32'(mem_req), 32'd0);
        chk("credit", 32'(pend.size() <= DEPTH), 32'd1);
        kill_prev = redir || invalidate;
        if (redir) begin
          exp_pc = tgt;
          req_exp = tgt;
        end else begin
          if (valid_out && !stall) exp_pc = exp_pc + 32'd4;
          if (mem_req && mem_gnt) req_exp = req_exp + 32'd4;
        end
      end
    end
  end

  initial begin
    logic [31:0] held_pc;
    bit seen;
    reset_n = 1'b0;
    branch = 1'b0; trap = 1'b0; mret = 1'b0;
    stall = 1'b0; invalidate = 1'b0;
    branch_vector = '0; trap_vector = '0; mret_vector = '0;
    mem_gnt = 1'b1;

    #23;
    chk("rst_pc", pc_out, RV);
    chk("rst_next_pc", next_pc_out, 32'h8000_0004);
    chk("rst_ins", instruction_out, 32'h0000_0013);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);

    // Reset release and first-fetch latency
    tick();
    reset_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("first_req", 32'(mem_req), 32'd1);
        chk("first_addr", mem_addr, RV);
      end
      if (k == 3) chk("valid_c3", 32'(valid_out), 32'd0);
      if (k == 4) begin
        chk("valid_c4", 32'(valid_out), 32'd1);
        chk("pc_c4", pc_out, 32'h8000_0000);
      end
    end
    repeat (8) tick();

    // Withheld responses: credit caps outstanding requests
    hold = 1'b1;
    repeat (10) tick();
    @(negedge clk);
    chk("full_outstanding", 32'(pend.size()), 32'(DEPTH));
    chk("full_req_off", 32'(mem_req), 32'd0);
    tick();
    hold = 1'b0;
    repeat (8) tick();

    // Stall holds the slot, invalidate kills one cycle
    stall = 1'b1;
    @(negedge clk);
    held_pc = pc_out;
    chk("stall_valid_in", 32'(valid_out), 32'd1);
    repeat (5) tick();
    @(negedge clk);
    chk("stall_held_pc", pc_out, held_pc);
    chk("stall_held_valid", 32'(valid_out), 32'd1);
    tick();
    stall = 1'b0;
    repeat (3) tick();
    invalidate = 1'b1;
    tick();
    invalidate = 1'b0;
    @(negedge clk);
    chk("inv_valid", 32'(valid_out), 32'd0);
    repeat (4) tick();

    // Branch with three requests in flight
    mem_gnt = 1'b0;
    repeat (8) tick();
    mem_gnt = 1'b1;
    hold = 1'b1;
    repeat (3) tick();
    mem_gnt = 1'b0;
    branch = 1'b1;
    branch_vector = 32'h8000_0102;
    @(negedge clk);
    chk("inflight_3", 32'(pend.size()), 32'd3);
    tick();
    branch = 1'b0;
    hold = 1'b0;
    mem_gnt = 1'b1;
    @(negedge clk);
    chk("br_req", 32'(mem_req), 32'd1);
    chk("br_addr", mem_addr, 32'h8000_0100);
    chk("br_valid_off", 32'(valid_out), 32'd0);
    wait_valid("br_first", 32'h8000_0100);
    repeat (4) tick();

    // Simultaneous redirects: trap wins
    trap = 1'b1; mret = 1'b1; branch = 1'b1;
    trap_vector = 32'h0000_1001;
    mret_vector = 32'h0000_2000;
    branch_vector = 32'h0000_3000;
    tick();
    trap = 1'b0; mret = 1'b0; branch = 1'b0;
    wait_valid("trap_prio", 32'h0000_1000);
    repeat (3) tick();
    trap = 1'b1;
    trap_vector = 32'h0000_4000;
    stall = 1'b1;
    tick();
    trap = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    chk("trap_stall_valid", 32'(valid_out), 32'd0);
    wait_valid("trap_stall", 32'h0000_4000);

    // Address wrap
    tick();
    trap = 1'b1;
    trap_vector = 32'hFFFF_FFF8;
    tick();
    trap = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      if (mem_req && mem_gnt && mem_addr == 32'hFFFF_FFFC) seen = 1'b1;
    end
    chk("wrap_seen", 32'(seen), 32'd1);
    @(negedge clk);
    chk("wrap_addr", mem_addr, 32'h0000_0000);
    repeat (6) tick();

    // Asynchronous reset mid-burst
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_pc", pc_out, RV);
    chk("arst_next_pc", next_pc_out, 32'h8000_0004);
    chk("arst_ins", instruction_out, 32'h0000_0013);
    chk("arst_valid", 32'(valid_out), 32'd0);
    chk("arst_req", 32'(mem_req), 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    wait_valid("post_rst", RV);
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
